// File: rtl/jk_ff_bank_if.sv
// Signal bundle for jk_ff_bank: update controls, per-bit inputs and registered outputs.
// The master modport drives the controls; the slave modport is the flip-flop bank.
interface jk_ff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             ld;
    logic [WIDTH-1:0] d_ld;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;
    logic [WIDTH-1:0] chg;
    logic [CNT_W-1:0] chg_cnt;

    modport master (
        output en, mode, j, k, ld, d_ld,
        input  q1, q2, chg, chg_cnt
    );

    modport slave (
        input  en, mode, j, k, ld, d_ld,
        output q1, q2, chg, chg_cnt
    );
endinterface

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK flip-flops with JK/D/T/hold modes, parallel load and per-bit change strobes.
// Define JK_FF_BANK_CHG_CNT_EN to build the saturating change-event counter; otherwise chg_cnt is 0.
module jk_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    jk_ff_bank_if.slave   bus
);
    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_D    = 2'b01;
    localparam logic [1:0] MODE_T    = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    logic [WIDTH-1:0] q1_q;
    logic [WIDTH-1:0] q1_next;
    logic [WIDTH-1:0] chg_q;
    logic [WIDTH-1:0] diff;

    // NOTE: q1_next is defaulted to the current state before any branch, so every
    // path assigns it and no latch is inferred.
    always_comb begin
        q1_next = q1_q;
        if (bus.ld) begin
            q1_next = bus.d_ld;
        end else if (bus.en) begin
            case (bus.mode)
                MODE_JK:   q1_next = (bus.j & ~q1_q) | (~bus.k & q1_q);
                MODE_D:    q1_next = bus.j;
                MODE_T:    q1_next = q1_q ^ bus.j;
                MODE_HOLD: q1_next = q1_q;
                default:   q1_next = q1_q;
            endcase
        end
    end

    assign diff = q1_next ^ q1_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_q  <= RST_VAL;
            chg_q <= '0;
        end else begin
            q1_q  <= q1_next;
            chg_q <= diff;
        end
    end

`ifdef JK_FF_BANK_CHG_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturates at all-ones; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((|diff) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.chg_cnt = cnt_q;
`else
    assign bus.chg_cnt = '0;
`endif

    assign bus.q1  = q1_q;
    assign bus.q2  = ~q1_q;
    assign bus.chg = chg_q;
endmodule
